// File: rtl/tmds_rx_decoder.sv
// ---------------------------------------------------------------------------
// tmds_rx_decoder
//   Recovers video from three deserialized 10-bit TMDS words. Stage 1
//   registers the raw words; stage 2 classifies the cycle (control / data /
//   error), decodes the colour bytes, and registers every output.
//   A small FSM tracks frame position so the first active pixel after a
//   VSYNC rising edge is flagged.
//
// Ports
//   clk_25p2MHz  in   pixel clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   tmds_ch0     in   10-bit word, blue channel (carries HSYNC/VSYNC)
//   tmds_ch1     in   10-bit word, green channel
//   tmds_ch2     in   10-bit word, red channel
//   rgb          out  {r[7:4], g[7:4], b[7:4]}
//   de           out  data enable, high during active video
//   hsync/vsync  out  recovered sync levels from ch0 control tokens
//   pix_x/pix_y  out  position of the pixel currently on rgb
//   frame_start  out  one-cycle pulse on the first active pixel of a frame
//   err_cnt      out  saturating count of channel-disagreement cycles
// ---------------------------------------------------------------------------
module tmds_rx_decoder #(
    parameter int POS_W    = 10,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk_25p2MHz,
    input  logic                rst,
    input  logic [9:0]          tmds_ch0,
    input  logic [9:0]          tmds_ch1,
    input  logic [9:0]          tmds_ch2,
    output logic [11:0]         rgb,
    output logic                de,
    output logic                hsync,
    output logic                vsync,
    output logic [POS_W-1:0]    pix_x,
    output logic [POS_W-1:0]    pix_y,
    output logic                frame_start,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        WAIT_DE = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [POS_W-1:0]    POS_ONE = POS_W'(1);
    localparam logic [ERRCNT_W-1:0] ERR_ONE = ERRCNT_W'(1);

    // True when the word is one of the four control tokens.
    function automatic logic f_is_ctrl(input logic [9:0] d);
        return (d == 10'b1101010100) || (d == 10'b0010101011) ||
               (d == 10'b0101010100) || (d == 10'b1010101011);
    endfunction

    // {c1, c0} carried by a control token.
    function automatic logic [1:0] f_ctrl_bits(input logic [9:0] d);
        logic [1:0] c;
        case (d)
            10'b0010101011: c = 2'b01;
            10'b0101010100: c = 2'b10;
            10'b1010101011: c = 2'b11;
            default:        c = 2'b00;
        endcase
        return c;
    endfunction

    // Data decode restricted to the upper nibble, which is all that reaches
    // rgb. Bit 4 needs t[3], so the word is taken from bit 3 upwards.
    function automatic logic [3:0] f_decode_hi(input logic [9:3] d);
        logic [7:3] t;
        logic [7:4] q;
        t = d[9] ? ~d[7:3] : d[7:3];
        for (int i = 4; i < 8; i++) begin
            q[i] = d[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return q;
    endfunction

    logic [9:0] w_in      [3];
    logic [3:0] w_hi      [3];
    logic       w_is_ctrl [3];
    logic [1:0] w_cbits;

    assign w_in[0] = tmds_ch0;
    assign w_in[1] = tmds_ch1;
    assign w_in[2] = tmds_ch2;

    // Stage 1: one input register per channel, plus per-channel decode of
    // the registered word.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [9:0] r_word;
            always_ff @(posedge clk_25p2MHz or posedge rst) begin
                if (rst) r_word <= '0;
                else     r_word <= w_in[gi];
            end
            assign w_hi[gi]      = f_decode_hi(r_word[9:3]);
            assign w_is_ctrl[gi] = f_is_ctrl(r_word);
        end
    endgenerate

    assign w_cbits = f_ctrl_bits(g_ch[0].r_word);

    // Stage 1 holds reset zeros for one cycle after release; those are not
    // real input and must not be decoded.
    logic r_s1_valid;
    always_ff @(posedge clk_25p2MHz or posedge rst) begin
        if (rst) r_s1_valid <= 1'b0;
        else     r_s1_valid <= 1'b1;
    end

    logic [11:0]         r_rgb;
    logic                r_de;
    logic                r_hsync;
    logic                r_vsync;
    logic [POS_W-1:0]    r_pix_x;
    logic [POS_W-1:0]    r_pix_y;
    logic                r_frame_start;
    logic [ERRCNT_W-1:0] r_err_cnt;
    state_t              r_state;

    logic                w_all_ctrl;
    logic                w_no_ctrl;
    logic                w_err;
    logic                w_de_next;
    logic [11:0]         w_rgb_next;
    logic                w_hsync_next;
    logic                w_vsync_next;
    logic                w_vs_rise;
    logic                w_line_end;
    logic [POS_W-1:0]    w_pix_x_next;
    logic [POS_W-1:0]    w_pix_y_next;

    always_comb begin
        w_all_ctrl   = w_is_ctrl[0] & w_is_ctrl[1] & w_is_ctrl[2];
        w_no_ctrl    = ~(w_is_ctrl[0] | w_is_ctrl[1] | w_is_ctrl[2]);
        w_err        = ~w_all_ctrl & ~w_no_ctrl;
        w_de_next    = w_no_ctrl;
        w_rgb_next   = w_no_ctrl ? {w_hi[2], w_hi[1], w_hi[0]} : 12'h000;
        // Sync levels only move on clean control cycles.
        w_hsync_next = w_all_ctrl ? w_cbits[0] : r_hsync;
        w_vsync_next = w_all_ctrl ? w_cbits[1] : r_vsync;
        w_vs_rise    = w_vsync_next & ~r_vsync;
        w_line_end   = r_de & ~w_de_next;

        w_pix_x_next = r_pix_x;
        if (w_de_next) begin
            if (!r_de)                 w_pix_x_next = '0;
            else if (r_pix_x != '1)    w_pix_x_next = r_pix_x + POS_ONE;
        end

        // A VSYNC edge and a line end cannot both matter: clear wins.
        w_pix_y_next = r_pix_y;
        if (w_vs_rise)                             w_pix_y_next = '0;
        else if (w_line_end && (r_pix_y != '1))    w_pix_y_next = r_pix_y + POS_ONE;
    end

    // Stage 2 output registers.
    always_ff @(posedge clk_25p2MHz or posedge rst) begin
        if (rst) begin
            r_rgb     <= '0;
            r_de      <= 1'b0;
            r_hsync   <= 1'b0;
            r_vsync   <= 1'b0;
            r_pix_x   <= '0;
            r_pix_y   <= '0;
            r_err_cnt <= '0;
        end else if (r_s1_valid) begin
            r_rgb   <= w_rgb_next;
            r_de    <= w_de_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_pix_x <= w_pix_x_next;
            r_pix_y <= w_pix_y_next;
            if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_ONE;
        end
    end

    // Frame tracker: frame_start is registered alongside the stage-2 outputs
    // so it lines up with the first active pixel on rgb.
    always_ff @(posedge clk_25p2MHz or posedge rst) begin
        if (rst) begin
            r_state       <= WAIT_VS;
            r_frame_start <= 1'b0;
        end else if (r_s1_valid) begin
            r_frame_start <= 1'b0;
            case (r_state)
                WAIT_VS: if (w_vs_rise) r_state <= WAIT_DE;
                WAIT_DE: begin
                    if (w_de_next) begin
                        r_state       <= ACTIVE;
                        r_frame_start <= 1'b1;
                    end
                end
                ACTIVE:  if (w_vs_rise) r_state <= WAIT_DE;
                default: r_state <= WAIT_VS;
            endcase
        end
    end

    assign rgb         = r_rgb;
    assign de          = r_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_rx_decoder
//   Drives encoded TMDS words into two decoder instances (default widths and
//   narrow 3-bit counters so saturation is reachable) and compares every
//   output cycle against a behavioural model built from the original bytes,
//   sync levels and a frame-armed flag.
// ---------------------------------------------------------------------------
module tb_tmds_rx_decoder;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;
    localparam int K_CTRL = 0;
    localparam int K_DATA = 1;
    localparam int K_ERR  = 2;

    logic        clk;
    logic        rst;
    logic [9:0]  ch0, ch1, ch2;

    logic [11:0] rgb_a, rgb_b;
    logic        de_a, de_b, hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
    logic [9:0]  px_a, py_a;
    logic [15:0] err_a;
    logic [2:0]  px_b, py_b, err_b;

    tmds_rx_decoder u_dut_a (
        .clk_25p2MHz(clk), .rst(rst),
        .tmds_ch0(ch0), .tmds_ch1(ch1), .tmds_ch2(ch2),
        .rgb(rgb_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
        .pix_x(px_a), .pix_y(py_a), .frame_start(fs_a), .err_cnt(err_a)
    );

    tmds_rx_decoder #(.POS_W(3), .ERRCNT_W(3)) u_dut_b (
        .clk_25p2MHz(clk), .rst(rst),
        .tmds_ch0(ch0), .tmds_ch1(ch1), .tmds_ch2(ch2),
        .rgb(rgb_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
        .pix_x(px_b), .pix_y(py_b), .frame_start(fs_b), .err_cnt(err_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [11:0] rgb;
        logic        de, hs, vs, fs;
        int          x0, y0, e0, x1, y1, e1;
    } exp_t;

    exp_t q[$];

    // Model state
    int m_x[2], m_y[2], m_e[2];
    bit m_prev_de, m_hs, m_vs, m_armed;
    int XMAX[2] = '{1023, 7};
    int EMAX[2] = '{65535, 7};

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic bit is_tok(input logic [9:0] w);
        return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
    endfunction

    function automatic logic [9:0] tok_of(input logic [1:0] c);
        case (c)
            2'b00:   return TOK0;
            2'b01:   return TOK1;
            2'b10:   return TOK2;
            default: return TOK3;
        endcase
    endfunction

    // TMDS-style transition encoding of a byte with chosen xor/invert flags.
    function automatic logic [9:0] enc(input logic [7:0] d, input bit x8, input bit x9);
        logic [7:0] qm;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = x8 ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
        return {x9, x8, (x9 ? ~qm : qm)};
    endfunction

    // Random flag choice, skipping any combination that collides with a token.
    function automatic logic [9:0] enc_rand(input logic [7:0] d);
        logic [9:0] w;
        int s;
        s = $urandom_range(0, 3);
        w = '0;
        for (int k = 0; k < 4; k++) begin
            int cb;
            cb = (s + k) % 4;
            w = enc(d, cb[0], cb[1]);
            if (!is_tok(w)) return w;
        end
        return w;
    endfunction

    function automatic logic [9:0] rand_tok();
        logic [1:0] c;
        c = 2'($urandom_range(0, 3));
        return tok_of(c);
    endfunction

    task automatic compare(input exp_t e);
        check_eq("a_de",  32'(de_a),  32'(e.de));
        check_eq("b_de",  32'(de_b),  32'(e.de));
        check_eq("a_rgb", 32'(rgb_a), 32'(e.rgb));
        check_eq("b_rgb", 32'(rgb_b), 32'(e.rgb));
        check_eq("a_hs",  32'(hs_a),  32'(e.hs));
        check_eq("b_hs",  32'(hs_b),  32'(e.hs));
        check_eq("a_vs",  32'(vs_a),  32'(e.vs));
        check_eq("b_vs",  32'(vs_b),  32'(e.vs));
        check_eq("a_fs",  32'(fs_a),  32'(e.fs));
        check_eq("b_fs",  32'(fs_b),  32'(e.fs));
        check_eq("a_err", 32'(err_a), 32'(e.e0));
        check_eq("b_err", 32'(err_b), 32'(e.e1));
        if (e.de) begin
            check_eq("a_px", 32'(px_a), 32'(e.x0));
            check_eq("a_py", 32'(py_a), 32'(e.y0));
            check_eq("b_px", 32'(px_b), 32'(e.x1));
            check_eq("b_py", 32'(py_b), 32'(e.y1));
        end
    endtask

    task automatic check_zero(input string tag);
        exp_t z;
        z = '{rgb: 12'h000, de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0,
              x0: 0, y0: 0, e0: 0, x1: 0, y1: 0, e1: 0};
        compare(z);
        check_eq({tag, "_a_px"}, 32'(px_a), 32'd0);
        check_eq({tag, "_a_py"}, 32'(py_a), 32'd0);
        check_eq({tag, "_b_px"}, 32'(px_b), 32'd0);
        check_eq({tag, "_b_py"}, 32'(py_b), 32'd0);
    endtask

    task automatic model_reset();
        exp_t z;
        for (int k = 0; k < 2; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_e[k] = 0;
        end
        m_prev_de = 0; m_hs = 0; m_vs = 0; m_armed = 0;
        q.delete();
        // The cycle right after release still shows reset values.
        z = '{rgb: 12'h000, de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0,
              x0: 0, y0: 0, e0: 0, x1: 0, y1: 0, e1: 0};
        q.push_back(z);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #7;
        rst = 1'b1;
        #1;
        check_zero({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_zero({tag, "_hold"});
        model_reset();
        $display("txn reset %s", tag);
    endtask

    // One pixel-clock transaction: check the output due now, drive the next
    // input words, and queue the model's expectation for two cycles later.
    task automatic cyc(input int kind, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [1:0] c, input logic [2:0] emask);
        exp_t e, old;
        logic [2:0] mask;
        logic [9:0] w [3];
        bit new_de, new_hs, new_vs, vs_rise;
        @(negedge clk);
        if (rst) rst = 1'b0;
        if (q.size() == 2) begin
            old = q.pop_front();
            compare(old);
        end
        case (kind)
            K_CTRL: begin
                w[0] = tok_of(c); w[1] = rand_tok(); w[2] = rand_tok();
            end
            K_DATA: begin
                w[0] = enc_rand(b); w[1] = enc_rand(g); w[2] = enc_rand(r);
            end
            default: begin
                mask = (emask != 3'b000) ? emask : 3'($urandom_range(1, 6));
                for (int i = 0; i < 3; i++)
                    w[i] = mask[i] ? rand_tok() : enc_rand(8'($urandom_range(0, 255)));
            end
        endcase
        ch0 = w[0]; ch1 = w[1]; ch2 = w[2];

        new_de  = (kind == K_DATA);
        new_hs  = (kind == K_CTRL) ? c[0] : m_hs;
        new_vs  = (kind == K_CTRL) ? c[1] : m_vs;
        vs_rise = new_vs && !m_vs;
        for (int k = 0; k < 2; k++) begin
            if (new_de) m_x[k] = m_prev_de ? sat_inc(m_x[k], XMAX[k]) : 0;
            if (vs_rise)                   m_y[k] = 0;
            else if (m_prev_de && !new_de) m_y[k] = sat_inc(m_y[k], XMAX[k]);
            if (kind == K_ERR)             m_e[k] = sat_inc(m_e[k], EMAX[k]);
        end
        e.fs = new_de && m_armed;
        if (new_de)  m_armed = 0;
        if (vs_rise) m_armed = 1;
        e.de  = new_de;
        e.rgb = new_de ? {r[7:4], g[7:4], b[7:4]} : 12'h000;
        e.hs  = new_hs;
        e.vs  = new_vs;
        e.x0 = m_x[0]; e.y0 = m_y[0]; e.e0 = m_e[0];
        e.x1 = m_x[1]; e.y1 = m_y[1]; e.e1 = m_e[1];
        m_prev_de = new_de; m_hs = new_hs; m_vs = new_vs;
        q.push_back(e);
    endtask

    task automatic run(input int kind, input int len, input logic [1:0] c,
                       input logic [2:0] emask, input string what);
        for (int i = 0; i < len; i++)
            cyc(kind, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), c, emask);
        $display("txn %s kind=%0d len=%0d c=%0d checks=%0d", what, kind, len, c, checks);
    endtask

    task automatic flush();
        exp_t old;
        while (q.size() > 0) begin
            @(negedge clk);
            old = q.pop_front();
            compare(old);
        end
    endtask

    initial begin
        rst = 1'b0;
        ch0 = TOK0; ch1 = TOK0; ch2 = TOK0;
        do_reset("power_on");

        // hsync from ch0 token, with blank tokens first
        run(K_CTRL, 2, 2'b00, 3'b000, "ctrl_blank");
        run(K_CTRL, 3, 2'b01, 3'b000, "ctrl_hsync");

        // Active data before any vsync edge: decoded, never frame_start
        run(K_DATA, 6, 2'b00, 3'b000, "data_pre_vsync");
        run(K_CTRL, 3, 2'b00, 3'b000, "ctrl_gap");

        // vsync rising edge, then the 0xF0/0xA0/0x30 pattern
        run(K_CTRL, 3, 2'b10, 3'b000, "vsync_high");
        run(K_CTRL, 2, 2'b00, 3'b000, "vsync_low");
        for (int i = 0; i < 4; i++) cyc(K_DATA, 8'h30, 8'hA0, 8'hF0, 2'b00, 3'b000);
        $display("txn fixed_pattern len=4 checks=%0d", checks);
        run(K_CTRL, 4, 2'b01, 3'b000, "hblank");

        // Two full 640-pixel lines, then vsync edge clears pix_y
        run(K_DATA, 640, 2'b00, 3'b000, "line0");
        run(K_CTRL, 8, 2'b01, 3'b000, "hblank");
        run(K_DATA, 640, 2'b00, 3'b000, "line1");
        run(K_CTRL, 4, 2'b00, 3'b000, "hblank");
        run(K_CTRL, 2, 2'b10, 3'b000, "vsync_high");
        run(K_CTRL, 2, 2'b00, 3'b000, "vsync_low");
        run(K_DATA, 10, 2'b00, 3'b000, "line0_next_frame");

        // Error cycles: ch0 token with data on ch1/ch2, then enough to saturate
        run(K_CTRL, 2, 2'b00, 3'b000, "ctrl_gap");
        run(K_ERR, 3, 2'b00, 3'b001, "err_ch0_tok");
        run(K_ERR, 8, 2'b00, 3'b000, "err_saturate");
        run(K_DATA, 5, 2'b00, 3'b000, "data_pre_err");
        run(K_ERR, 1, 2'b00, 3'b110, "err_midline");
        run(K_DATA, 5, 2'b00, 3'b000, "data_post_err");

        // Randomized mix of bursts
        for (int n = 0; n < 300; n++) begin
            int p, len;
            logic [1:0] c;
            p   = $urandom_range(0, 99);
            len = $urandom_range(1, 40);
            c   = {($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1))};
            if (p < 55)      run(K_DATA, len, 2'b00, 3'b000, "rand_data");
            else if (p < 92) run(K_CTRL, len, c, 3'b000, "rand_ctrl");
            else             run(K_ERR, $urandom_range(1, 3), 2'b00, 3'b000, "rand_err");
        end

        // Reset during an active line, then re-arm only via a new vsync edge
        run(K_CTRL, 2, 2'b10, 3'b000, "vsync_high");
        run(K_CTRL, 2, 2'b00, 3'b000, "vsync_low");
        run(K_DATA, 10, 2'b00, 3'b000, "line_before_reset");
        do_reset("midline");
        run(K_DATA, 6, 2'b00, 3'b000, "data_after_reset");
        run(K_CTRL, 2, 2'b00, 3'b000, "ctrl_gap");
        run(K_DATA, 4, 2'b00, 3'b000, "data_still_unarmed");
        run(K_CTRL, 2, 2'b10, 3'b000, "vsync_high");
        run(K_CTRL, 2, 2'b00, 3'b000, "vsync_low");
        run(K_DATA, 5, 2'b00, 3'b000, "line_rearmed");
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
